// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue and writeback stage in front of a 32-bit ALU.
// Serialised IDLE -> EXEC -> WB pipeline with one command in flight, backed by
// an internal NREG x N register file (r0 hard-wired to zero).
//
// Optional feature macro: ALU_ISSUE_OVF_TRAP_EN
//   When defined, an add/sub that retires with overflow suppresses its
//   register write and parks the stage in TRAP until flag_clr is seen.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on the stage state and
// ld_en (never on cmd_valid). A command that is offered but not accepted
// must be held stable by the producer until accepted.
module alu_issue_stage #(
  parameter int N    = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  // command port
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  // direct register load
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  // ALU interface
  output logic [N-1:0]  alu_X,
  output logic [N-1:0]  alu_Y,
  output logic [3:0]    alu_op,
  input  logic [N-1:0]  alu_Z,
  input  logic          alu_equal,
  input  logic          alu_overflow,
  input  logic          alu_zero,
  // retire
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [N-1:0]  wb_data,
  output logic          flag_equal,
  output logic          flag_zero,
  output logic          flag_ovf,
  output logic          sticky_ovf,
  input  logic          flag_clr,
  output logic          bad_op,
  // debug
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_ISSUE_OVF_TRAP_EN
    S_WB   = 2'd2,
    S_TRAP = 2'd3
`else
    S_WB   = 2'd2
`endif
  } state_t;

  state_t        state_q, state_d;

  logic [N-1:0]  regs_q [NREG];

  logic [N-1:0]  alu_x_q, alu_y_q;
  logic [3:0]    alu_op_q;
  logic [AW-1:0] rd_q;

  logic          wb_valid_q;
  logic [AW-1:0] wb_rd_q;
  logic [N-1:0]  wb_data_q;
  logic          flag_eq_q, flag_zero_q, flag_ovf_q;
  logic          bad_op_q;
  logic          wr_en_q;
  logic          sticky_q, sticky_d;

  logic          accept;
  logic          op_reserved;
  logic          op_arith;
  logic          ovf_masked;
  logic          wr_allowed;

  // Decode of the in-flight op (alu_op_q is stable through EXEC and WB).
  always_comb begin
    op_reserved = (alu_op_q == 4'd4) || (alu_op_q >= 4'd11);
    op_arith    = (alu_op_q == 4'd5) || (alu_op_q == 4'd6);
    ovf_masked  = alu_overflow & op_arith;
`ifdef ALU_ISSUE_OVF_TRAP_EN
    wr_allowed  = (rd_q != '0) && !op_reserved && !ovf_masked;
`else
    wr_allowed  = (rd_q != '0) && !op_reserved;
`endif
  end

  // Handshake: only an idle stage with no competing load accepts.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !ld_en;
    accept    = cmd_ready && cmd_valid;
  end

  // Next-state logic for the serialised issue/execute/writeback sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
`ifdef ALU_ISSUE_OVF_TRAP_EN
      S_WB:   state_d = flag_ovf_q ? S_TRAP : S_IDLE;
      S_TRAP: if (flag_clr) state_d = S_IDLE;
`else
      S_WB:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Operand issue: sample sources and op on the accept edge, hold until next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      alu_op_q <= '0;
      rd_q     <= '0;
    end else if (accept) begin
      alu_x_q  <= (cmd_rs == '0) ? '0 : regs_q[cmd_rs];
      alu_y_q  <= (cmd_rt == '0) ? '0 : regs_q[cmd_rt];
      alu_op_q <= cmd_op;
      rd_q     <= cmd_rd;
    end
  end

  // End of EXEC: capture the settled ALU result and flags for the WB cycle.
  // Reserved ops retire with all flags forced low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      flag_eq_q   <= 1'b0;
      flag_zero_q <= 1'b0;
      flag_ovf_q  <= 1'b0;
      bad_op_q    <= 1'b0;
      wr_en_q     <= 1'b0;
    end else if (state_q == S_EXEC) begin
      wb_valid_q  <= 1'b1;
      wb_rd_q     <= rd_q;
      wb_data_q   <= alu_Z;
      flag_eq_q   <= alu_equal & !op_reserved;
      flag_zero_q <= alu_zero  & !op_reserved;
      flag_ovf_q  <= ovf_masked;
      bad_op_q    <= op_reserved;
      wr_en_q     <= wr_allowed;
    end else begin
      wb_valid_q  <= 1'b0;
      bad_op_q    <= 1'b0;
      wr_en_q     <= 1'b0;
    end
  end

  // Sticky overflow accumulates retired overflows; a clear in the same cycle wins.
  always_comb begin
    sticky_d = sticky_q;
    if (flag_clr)                            sticky_d = 1'b0;
    else if (state_q == S_WB && flag_ovf_q)  sticky_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  // Register file: loads only land in IDLE, writeback only at the end of WB,
  // so the two write sources never collide. r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == S_IDLE && ld_en && ld_addr != '0) begin
      regs_q[ld_addr] <= ld_data;
    end else if (state_q == S_WB && wr_en_q) begin
      regs_q[wb_rd_q] <= wb_data_q;
    end
  end

  // Output mapping; dbg_data is a plain read, so it shows the pre-write value.
  always_comb begin
    alu_X      = alu_x_q;
    alu_Y      = alu_y_q;
    alu_op     = alu_op_q;
    wb_valid   = wb_valid_q;
    wb_rd      = wb_rd_q;
    wb_data    = wb_data_q;
    flag_equal = flag_eq_q;
    flag_zero  = flag_zero_q;
    flag_ovf   = flag_ovf_q;
    sticky_ovf = sticky_q;
    bad_op     = bad_op_q;
    dbg_data   = regs_q[dbg_addr];
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a behavioural 32-bit ALU model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs, cmd_rt;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_X, alu_Y, alu_Z;
  logic [3:0]  alu_op;
  logic        alu_equal, alu_overflow, alu_zero;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flag_equal, flag_zero, flag_ovf, sticky_ovf, flag_clr, bad_op;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_X(alu_X), .alu_Y(alu_Y), .alu_op(alu_op), .alu_Z(alu_Z),
    .alu_equal(alu_equal), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_equal(flag_equal), .flag_zero(flag_zero), .flag_ovf(flag_ovf),
    .sticky_ovf(sticky_ovf), .flag_clr(flag_clr), .bad_op(bad_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. Unlisted ops produce an add with a raw overflow so
  // the stage's masking of reserved ops is exercised.
  always_comb begin
    alu_Z        = alu_X + alu_Y;
    alu_overflow = (alu_X[31] == alu_Y[31]) && (alu_Z[31] != alu_X[31]);
    case (alu_op)
      4'd0:  begin alu_Z = alu_X & alu_Y;    alu_overflow = 1'b0; end
      4'd1:  begin alu_Z = alu_X | alu_Y;    alu_overflow = 1'b0; end
      4'd2:  begin alu_Z = alu_X ^ alu_Y;    alu_overflow = 1'b0; end
      4'd3:  begin alu_Z = ~(alu_X | alu_Y); alu_overflow = 1'b0; end
      4'd6:  begin
        alu_Z        = alu_X - alu_Y;
        alu_overflow = (alu_X[31] != alu_Y[31]) && (alu_Z[31] != alu_X[31]);
      end
      4'd7:  begin alu_Z = {31'd0, $signed(alu_X) < $signed(alu_Y)}; alu_overflow = 1'b0; end
      4'd8:  begin alu_Z = alu_X >> alu_Y[4:0];  alu_overflow = 1'b0; end
      4'd9:  begin alu_Z = alu_X << alu_Y[4:0];  alu_overflow = 1'b0; end
      4'd10: begin alu_Z = $signed(alu_X) >>> alu_Y[4:0]; alu_overflow = 1'b0; end
      default: ;
    endcase
    alu_equal = (alu_X == alu_Y);
    alu_zero  = (alu_Z == 32'd0);
  end

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver: one-cycle register load, returns on the following negedge.
  task automatic do_load(input logic [4:0] addr, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Driver: offer a command from IDLE; returns at the negedge inside WB.
  task automatic run_cmd(input logic [3:0] op, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    #1;
    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  int n_acc;
  int n_wb;
  int acc_cyc[3];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; flag_clr = 1'b0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready",  {31'd0, cmd_ready},  32'd1);
    chk("rst_wb",     {31'd0, wb_valid},   32'd0);
    chk("rst_state",  {30'd0, dbg_state},  32'd0);
    chk("rst_alux",   alu_X,               32'd0);
    chk("rst_sticky", {31'd0, sticky_ovf}, 32'd0);

    // Add, with the r2 load overlapping an offered command
    @(negedge clk);
    do_load(5'd1, 32'd5);
    ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'd7; dbg_addr = 5'd2;
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_rd = 5'd3; cmd_rs = 5'd1; cmd_rt = 5'd2;
    #1;
    chk("ld_blocks_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    ld_en = 1'b0;
    #1;
    chk("ld_r2",          dbg_data,             32'd7);
    chk("ready_after_ld", {31'd0, cmd_ready},   32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; dbg_addr = 5'd3;
    #1;
    chk("exec_state", {30'd0, dbg_state}, 32'd1);
    chk("exec_ready", {31'd0, cmd_ready}, 32'd0);
    chk("exec_wb",    {31'd0, wb_valid},  32'd0);
    chk("add_x",      alu_X,              32'd5);
    chk("add_y",      alu_Y,              32'd7);
    chk("add_op",     {28'd0, alu_op},    32'd5);
    @(negedge clk);
    #1;
    chk("add_wbv",    {31'd0, wb_valid},   32'd1);
    chk("add_wbd",    wb_data,             32'd12);
    chk("add_wbrd",   {27'd0, wb_rd},      32'd3);
    chk("add_zero",   {31'd0, flag_zero},  32'd0);
    chk("add_eq",     {31'd0, flag_equal}, 32'd0);
    chk("add_rbw",    dbg_data,            32'd0);
    @(negedge clk);
    #1;
    chk("add_r3",     dbg_data,            32'd12);
    chk("add_wbv_lo", {31'd0, wb_valid},   32'd0);
    chk("add_hold",   wb_data,             32'd12);

    // Sub to zero into r0
    do_load(5'd1, 32'h1234);
    do_load(5'd2, 32'h1234);
    dbg_addr = 5'd0;
    run_cmd(4'd6, 5'd0, 5'd1, 5'd2);
    chk("sub_wbd",  wb_data,             32'd0);
    chk("sub_zero", {31'd0, flag_zero},  32'd1);
    chk("sub_eq",   {31'd0, flag_equal}, 32'd1);
    chk("sub_ovf",  {31'd0, flag_ovf},   32'd0);
    @(negedge clk);
    #1;
    chk("sub_r0", dbg_data, 32'd0);

    // Signed overflow on add
    do_load(5'd1, 32'h7FFF_FFFF);
    do_load(5'd2, 32'd1);
    dbg_addr = 5'd4;
    run_cmd(4'd5, 5'd4, 5'd1, 5'd2);
    chk("ovf_wbv", {31'd0, wb_valid}, 32'd1);
    chk("ovf_flag", {31'd0, flag_ovf}, 32'd1);
    chk("ovf_wbd", wb_data, 32'h8000_0000);
    @(negedge clk);
    #1;
    chk("ovf_sticky", {31'd0, sticky_ovf}, 32'd1);
`ifdef ALU_ISSUE_OVF_TRAP_EN
    chk("trap_ready", {31'd0, cmd_ready}, 32'd0);
    chk("trap_r4",    dbg_data,           32'd0);
    chk("trap_state", {30'd0, dbg_state}, 32'd3);
`else
    chk("ovf_r4",     dbg_data,           32'h8000_0000);
    chk("ovf_ready",  {31'd0, cmd_ready}, 32'd1);
`endif
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    #1;
    chk("clr_sticky", {31'd0, sticky_ovf}, 32'd0);
    chk("clr_ready",  {31'd0, cmd_ready},  32'd1);

    // Reserved op 12 with equal operands and raw ALU overflow
    do_load(5'd5, 32'h55);
    dbg_addr = 5'd5;
    run_cmd(4'd12, 5'd5, 5'd1, 5'd1);
    chk("rsv_wbv",  {31'd0, wb_valid},   32'd1);
    chk("rsv_bad",  {31'd0, bad_op},     32'd1);
    chk("rsv_eq",   {31'd0, flag_equal}, 32'd0);
    chk("rsv_zero", {31'd0, flag_zero},  32'd0);
    chk("rsv_ovf",  {31'd0, flag_ovf},   32'd0);
    @(negedge clk);
    #1;
    chk("rsv_bad_lo", {31'd0, bad_op},     32'd0);
    chk("rsv_r5",     dbg_data,            32'h55);
    chk("rsv_sticky", {31'd0, sticky_ovf}, 32'd0);

    // Back-to-back chain r1 = r1 + r1 starting from 1
    do_load(5'd1, 32'd1);
    exp_q = {32'd2, 32'd4, 32'd8};
    n_acc = 0; n_wb = 0;
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_rd = 5'd1; cmd_rs = 5'd1; cmd_rt = 5'd1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      if (wb_valid) begin
        n_wb++;
        if (exp_q.size() > 0) chk("b2b_wbd", wb_data, exp_q.pop_front());
        else                  chk("b2b_extra_wb", 32'd1, 32'd0);
      end
      if (cmd_valid && cmd_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 3) cmd_valid = 1'b0;
    end
    dbg_addr = 5'd1;
    #1;
    chk("b2b_nacc", n_acc, 32'd3);
    chk("b2b_nwb",  n_wb,  32'd3);
    chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
    chk("b2b_r1",   dbg_data, 32'd8);

    // Reset in the middle of EXEC
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd5; cmd_rd = 5'd7; cmd_rs = 5'd1; cmd_rt = 5'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("mid_exec", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst2_wb",    {31'd0, wb_valid},  32'd0);
    chk("rst2_alux",  alu_X,              32'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      chk("rst2_reg", dbg_data, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("rst2_no_wb", {31'd0, wb_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
